// File: rtl/seg7_pkg.sv
// Shared definitions for the seven-segment reader: active-low segment patterns
// (bit 6..0 = g..a) for hex digits 0..F, the all-off pattern, and the FSM state type.
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_A     = 7'b0001000;
  localparam logic [6:0] SEG_B     = 7'b0000011;
  localparam logic [6:0] SEG_C     = 7'b1000110;
  localparam logic [6:0] SEG_D     = 7'b0100001;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_F     = 7'b0001110;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {
    StIdle,
    StSettle,
    StHold
  } state_t;

endpackage

// File: rtl/seg7_match.sv
// Combinational pattern-to-digit lookup.
// Letters A..F are only recognised when SEG7_HEXLETTERS_EN is defined;
// otherwise they report no hit like any other unknown pattern.
module seg7_match
  import seg7_pkg::*;
(
  input  logic [6:0] pat,
  output logic [3:0] code,
  output logic       hit
);

  // Table lookup; unknown patterns give hit=0 and code=0.
  always_comb begin
    code = 4'h0;
    hit  = 1'b1;
    unique case (pat)
      SEG_0: code = 4'h0;
      SEG_1: code = 4'h1;
      SEG_2: code = 4'h2;
      SEG_3: code = 4'h3;
      SEG_4: code = 4'h4;
      SEG_5: code = 4'h5;
      SEG_6: code = 4'h6;
      SEG_7: code = 4'h7;
      SEG_8: code = 4'h8;
      SEG_9: code = 4'h9;
`ifdef SEG7_HEXLETTERS_EN
      SEG_A: code = 4'hA;
      SEG_B: code = 4'hB;
      SEG_C: code = 4'hC;
      SEG_D: code = 4'hD;
      SEG_E: code = 4'hE;
      SEG_F: code = 4'hF;
`endif
      default: hit = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg7_reader.sv
// Seven-segment display reader: debounces the registered leds pattern, decodes it
// to a hex digit and offers it on a valid/ready handshake. Blank and unknown
// patterns are reported on blank (level) and err (one-cycle pulse).
// Optional feature macro: SEG7_HEXLETTERS_EN (decode A..F as digits 0xA..0xF).
module seg7_reader
  import seg7_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] leds,
  input  logic       out_ready,
  output logic [3:0] bcd,
  output logic       out_valid,
  output logic       err,
  output logic       blank
);

  localparam int unsigned CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CntOne = CW'(1);
  localparam logic [CW-1:0] CntMax = CW'(STABLE_CYCLES);
  localparam logic [CW:0]   CntMaxW = (CW+1)'(STABLE_CYCLES);
  // With a single required sample the first differing sample is already accepted.
  localparam bit OneShot = (STABLE_CYCLES == 1);

  state_t       state_q, state_d;
  logic [6:0]   leds_q;
  logic [6:0]   cand_q, cand_d;
  logic [6:0]   last_q, last_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW:0]  cnt_inc;
  logic [3:0]   bcd_q, bcd_d;
  logic         valid_q, valid_d;
  logic         err_q, err_d;
  logic         blank_q, blank_d;
  logic         accept;
  logic [3:0]   code;
  logic         hit;

  // Lookup runs on the candidate being committed this cycle.
  seg7_match u_match (
    .pat  (cand_d),
    .code (code),
    .hit  (hit)
  );

  assign cnt_inc = {1'b0, cnt_q} + {{CW{1'b0}}, 1'b1};

  // State and output registers, asynchronously reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      leds_q  <= SEG_BLANK;
      cand_q  <= SEG_BLANK;
      last_q  <= SEG_BLANK;
      cnt_q   <= '0;
      bcd_q   <= 4'h0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      blank_q <= 1'b1;
    end else begin
      state_q <= state_d;
      leds_q  <= leds;
      cand_q  <= cand_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      bcd_q   <= bcd_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      blank_q <= blank_d;
    end
  end

  // Next-state: candidate tracking, stability counting and acceptance.
  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    accept  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (leds_q != last_q) begin
          cand_d = leds_q;
          cnt_d  = CntOne;
          if (OneShot) begin
            accept = 1'b1;
          end else begin
            state_d = StSettle;
          end
        end
      end
      StSettle: begin
        if (leds_q == cand_q) begin
          cnt_d = (cnt_inc >= CntMaxW) ? CntMax : cnt_inc[CW-1:0];
          // This sample completes the required run of identical samples.
          if (cnt_inc >= CntMaxW) begin
            accept = 1'b1;
          end
        end else begin
          cand_d = leds_q;
          cnt_d  = CntOne;
        end
      end
      StHold: begin
        if (valid_q && out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    if (accept) begin
      last_d  = cand_d;
      state_d = hit ? StHold : StIdle;
    end
  end

  // Output next values: digit handshake, blank level and err pulse.
  always_comb begin
    bcd_d   = bcd_q;
    valid_d = valid_q;
    err_d   = 1'b0;
    blank_d = blank_q;
    if (state_q == StHold && valid_q && out_ready) begin
      valid_d = 1'b0;
    end
    if (accept) begin
      if (hit) begin
        bcd_d   = code;
        valid_d = 1'b1;
        blank_d = 1'b0;
      end else if (cand_d == SEG_BLANK) begin
        blank_d = 1'b1;
      end else begin
        err_d   = 1'b1;
        blank_d = 1'b0;
      end
    end
  end

  assign bcd       = bcd_q;
  assign out_valid = valid_q;
  assign err       = err_q;
  assign blank     = blank_q;

endmodule

// File: tb/tb_seg7_reader.sv
// Self-checking bench for seg7_reader (STABLE_CYCLES = 4). Follows SEG7_HEXLETTERS_EN
// so the same bench covers both builds.
module tb_seg7_reader;

  localparam int S = 4;
`ifdef SEG7_HEXLETTERS_EN
  localparam int NDIG = 16;
`else
  localparam int NDIG = 10;
`endif

  localparam logic [6:0] TBL [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };
  localparam logic [6:0] OFF = 7'b1111111;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] leds;
  logic       out_ready;
  logic [3:0] bcd;
  logic       out_valid;
  logic       err;
  logic       blank;

  int checks = 0;
  int errors = 0;

  seg7_reader #(.STABLE_CYCLES(S)) dut (
    .clk       (clk),
    .reset     (reset),
    .leds      (leds),
    .out_ready (out_ready),
    .bcd       (bcd),
    .out_valid (out_valid),
    .err       (err),
    .blank     (blank)
  );

  always #5 clk = ~clk;

  // Reference model: what the display reader should report, derived from the
  // rule "a pattern seen on S consecutive registered samples is accepted".
  logic [6:0] m_samp;   // registered copy of leds
  logic [6:0] m_run_pat;
  int         m_run_len;
  bit         m_watch;  // a run is being measured
  bit         m_busy;   // a digit is waiting for the consumer
  logic [6:0] m_last;
  logic [3:0] e_bcd;
  logic       e_valid, e_err, e_blank;

  function automatic int find(input logic [6:0] p);
    for (int i = 0; i < 16; i++) if (TBL[i] == p) return i;
    return -1;
  endfunction

  task automatic model_reset();
    m_samp = OFF; m_run_pat = OFF; m_run_len = 0; m_watch = 0; m_busy = 0;
    m_last = OFF; e_bcd = 4'h0; e_valid = 0; e_err = 0; e_blank = 1;
  endtask

  task automatic model_edge();
    logic [6:0] s;
    int idx;
    s = m_samp;
    m_samp = leds;
    e_err = 0;
    if (m_busy) begin
      if (out_ready) begin m_busy = 0; e_valid = 0; end
    end else begin
      if (m_watch && s == m_run_pat) m_run_len++;
      else if (m_watch || s != m_last) begin m_run_pat = s; m_run_len = 1; m_watch = 1; end
      if (m_watch && m_run_len >= S) begin
        m_watch = 0;
        m_last = m_run_pat;
        idx = find(m_run_pat);
        if (idx >= 0 && idx < NDIG) begin
          m_busy = 1; e_valid = 1; e_bcd = 4'(idx); e_blank = 0;
        end else if (m_run_pat == OFF) begin
          e_blank = 1;
        end else begin
          e_err = 1; e_blank = 0;
        end
      end
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk("bcd", {4'h0, bcd}, {4'h0, e_bcd});
    chk("out_valid", {7'h0, out_valid}, {7'h0, e_valid});
    chk("err", {7'h0, err}, {7'h0, e_err});
    chk("blank", {7'h0, blank}, {7'h0, e_blank});
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic check_reset_outputs(input string tag);
    #1;
    chk({tag, "_bcd"}, {4'h0, bcd}, 8'h00);
    chk({tag, "_valid"}, {7'h0, out_valid}, 8'h00);
    chk({tag, "_err"}, {7'h0, err}, 8'h00);
    chk({tag, "_blank"}, {7'h0, blank}, 8'h01);
  endtask

  initial begin
    int n;
    int r;
    reset = 1'b1; leds = OFF; out_ready = 1'b0;
    model_reset();
    check_reset_outputs("reset");
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // All segments off for 20 cycles: nothing reported.
    steps(20);

    // Digit 2 with latency measured against fixed constants.
    leds = TBL[2]; out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      step();
      chk("lat_pre", {7'h0, out_valid}, 8'h00);
    end
    step();
    chk("lat_valid", {7'h0, out_valid}, 8'h01);
    chk("lat_bcd", {4'h0, bcd}, 8'h02);
    step();
    chk("lat_drop", {7'h0, out_valid}, 8'h00);
    steps(10);

    // Toggle 3/4 every two cycles, then settle on 4.
    for (int i = 0; i < 10; i++) begin
      leds = (i % 2 == 0) ? TBL[3] : TBL[4];
      steps(2);
    end
    leds = TBL[4];
    steps(10);

    // Digit 9 held back by the consumer while the display moves to 7.
    out_ready = 1'b0; leds = TBL[9];
    steps(8);
    leds = TBL[7];
    steps(10);
    chk("hold_bcd9", {4'h0, bcd}, 8'h09);
    out_ready = 1'b1;
    steps(15);

    // Unknown pattern, then letter A.
    leds = 7'b1010101;
    steps(10);
    leds = TBL[10];
    steps(10);

    // Reset during settling discards the candidate.
    leds = TBL[8];
    steps(2);
    @(negedge clk);
    reset = 1'b1; leds = OFF;
    model_reset();
    check_reset_outputs("midreset");
    @(negedge clk);
    reset = 1'b0;
    steps(10);
    chk("post_reset_blank", {7'h0, blank}, 8'h01);

    // Randomized patterns, hold times and consumer readiness.
    for (int k = 0; k < 120; k++) begin
      r = int'($urandom_range(0, 19));
      if (r < 16) leds = TBL[r];
      else if (r == 16) leds = OFF;
      else leds = 7'($urandom);
      n = int'($urandom_range(1, 8));
      for (int j = 0; j < n; j++) begin
        out_ready = ($urandom_range(0, 3) != 0);
        step();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg7_reader.md
SEG7_READER -- requirements
Module: seg7_reader

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 4, meaning consecutive identical samples required before a pattern is accepted (legal range 1..255).
REQ-002 SHALL have port clk, input, 1, the single clock; all state is updated on its rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port leds, input, 7, active-low segment pattern (bit 6..0 = g..a) as driven to a display.
REQ-005 SHALL have port out_ready, input, 1, consumer accepts bcd when high with out_valid.
REQ-006 SHALL have port bcd, output, 4, decoded hex digit.
REQ-007 SHALL have port out_valid, output, 1, bcd holds a decoded digit awaiting acceptance.
REQ-008 SHALL have port err, output, 1, one-cycle pulse: a stable pattern matched no table entry.
REQ-009 SHALL have port blank, output, 1, level: the last accepted pattern is all segments off (7'b1111111).

Function
REQ-010 SHALL register leds into leds_q every cycle; all decisions use leds_q only.
REQ-011 SHALL decode via the table (active-low): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, B=0000011, C=1000110, D=0100001, E=0000110, F=0001110.
REQ-012 SHALL implement FSM states IDLE, SETTLE, HOLD.
REQ-013 IDLE: when leds_q differs from last_pat, SHALL load leds_q into cand, clear counter to 1, go to SETTLE.
REQ-014 SETTLE: if leds_q equals cand, counter SHALL increment, saturating at STABLE_CYCLES; if it differs, cand reloads and counter returns to 1 (restart).
REQ-015 SETTLE with counter equal to STABLE_CYCLES and leds_q equal to cand: SHALL set last_pat=cand and then branch per REQ-016..018.
REQ-016 Valid table match: SHALL drive bcd=code, out_valid=1, blank=0, go to HOLD.
REQ-017 Pattern 1111111: SHALL set blank=1, no out_valid, no err, go to IDLE.
REQ-018 Any other pattern: SHALL pulse err for exactly one cycle, blank=0, go to IDLE; the same pattern SHALL NOT re-raise err until a different pattern is accepted.
REQ-019 HOLD: bcd and out_valid SHALL stay constant until out_valid&&out_ready, then out_valid clears next cycle and FSM returns to IDLE; leds changes during HOLD are ignored until IDLE.
REQ-020 Latency: a leds change to a new pattern held steady SHALL produce out_valid high exactly STABLE_CYCLES+1 cycles after the first clk edge sampling it.
REQ-021 Counter width SHALL be $clog2(STABLE_CYCLES+1) bits; no wrap permitted.
REQ-022 STABLE_CYCLES=1 SHALL accept a pattern after one matching registered sample.

Reset
REQ-023 On reset high, SHALL asynchronously force: state=IDLE, bcd=0, out_valid=0, err=0, blank=1, last_pat=cand=leds_q=7'b1111111, counter=0.
REQ-024 Reset asserted during SETTLE or HOLD SHALL discard the candidate/pending digit; no out_valid or err after release without fresh stimulus.

Configuration
REQ-025 With SEG7_HEXLETTERS_EN defined, patterns A..F SHALL decode to 4'hA..4'hF per REQ-011.
REQ-026 Without SEG7_HEXLETTERS_EN, patterns A..F SHALL be treated as unmatched (err per REQ-018); only 0..9 produce out_valid.

Structure
REQ-027 A shared package seg7_pkg SHALL hold the 16 active-low pattern constants, SEG_BLANK, and the FSM state enum type.
REQ-028 A combinational sub-module seg7_match (pattern in -> code, hit) SHALL perform table lookup; seg7_reader instantiates it once on cand.

Verification
REQ-029 Reset, leds=1111111 for 20 cycles -> out_valid=0, err=0, blank=1 throughout.
REQ-030 leds=0100100 (2) held, out_ready=1, STABLE_CYCLES=4 -> out_valid high exactly at edge 5 after change for one cycle, bcd=2; no repeat while held.
REQ-031 leds toggles 0110000/0011001 every 2 cycles for 20 cycles, then holds 0011001 -> no output during toggling; then bcd=4 once.
REQ-032 leds=0010000 (9), out_ready=0 for 10 cycles while leds changes to 1111000 -> bcd=9 held stable; after out_ready=1, bcd=9 accepted, then bcd=7 emitted.
REQ-033 leds=1010101 held -> err one-cycle pulse, then none; leds=0001000 -> bcd=A with SEG7_HEXLETTERS_EN, err pulse without it.
REQ-034 reset pulsed mid-SETTLE on leds=0000000 and released with leds=1111111 -> no out_valid, blank=1.
